// File: rtl/mmss_timer.sv
// MM:SS game timer: countdown/count-up with pause, cancel and latched done.
// Holds a BCD preset and count, its own per-second divider and registered display outputs.
module mmss_timer #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned PRESET_SEC   = 5,
  parameter int unsigned UP_LIMIT_SEC = 1380
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       mode,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       pressed,
  input  logic       cancel,
  output logic [3:0] minute2,
  output logic [3:0] minute1,
  output logic [3:0] second2,
  output logic [3:0] second1,
  output logic [1:0] select,
  output logic [1:0] state,
  output logic       finish,
  output logic       tick
);

  localparam int unsigned    DivW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax   = DivW'(TICK_DIV - 1);
  localparam logic [15:0]    PresetBcd = {4'(PRESET_SEC / 600), 4'((PRESET_SEC / 60) % 10),
                                          4'((PRESET_SEC % 60) / 10), 4'(PRESET_SEC % 10)};
  localparam logic [15:0]    UpLimBcd  = {4'(UP_LIMIT_SEC / 600), 4'((UP_LIMIT_SEC / 60) % 10),
                                          4'((UP_LIMIT_SEC % 60) / 10), 4'(UP_LIMIT_SEC % 10)};

  typedef enum logic [1:0] {
    StConfig = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  // Add or subtract one unit at digit pos with BCD carry/borrow; saturates at 59:59 / 00:00.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic [1:0] pos,
                                           input logic inc);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    logic [3:0]  dmax;
    r = v;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d    = r[4*i +: 4];
      dmax = (i % 2 == 0) ? 4'd9 : 4'd5;
      if (i == int'(pos)) c = 1'b1;
      if (c) begin
        if (inc) begin
          if (d >= dmax) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = dmax;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    if (c) r = inc ? 16'h5959 : 16'h0000;
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [15:0]     preset_q, preset_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     target;
  logic            run_mode_q, run_mode_d;
  logic [1:0]      select_q, select_d;
  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic            finish_q, finish_d;

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    count_d    = count_q;
    run_mode_d = run_mode_q;
    select_d   = select_q;
    div_d      = div_q;
    tick_d     = 1'b0;
    target     = run_mode_q ? UpLimBcd : 16'h0000;

    if (enable) begin
      unique case (state_q)
        StConfig: begin
          if (left)       select_d = select_q + 2'd1;
          else if (right) select_d = select_q - 2'd1;
          if (!mode) begin
            if (up)        preset_d = bcd_step(preset_q, select_q, 1'b1);
            else if (down) preset_d = bcd_step(preset_q, select_q, 1'b0);
          end
          if (pressed && (mode || preset_q != 16'h0000)) begin
            state_d    = StRun;
            count_d    = mode ? 16'h0000 : preset_q;
            run_mode_d = mode;
            div_d      = '0;
          end
        end
        StRun: begin
          if (cancel) begin
            state_d = StConfig;
          end else if (count_q == target) begin
            // Terminal tick landed last cycle.
            state_d = StDone;
          end else if (div_q == DivMax) begin
            div_d   = '0;
            tick_d  = 1'b1;
            count_d = bcd_step(count_q, 2'd0, run_mode_q);
            if (pressed && count_d != target) state_d = StPaused;
          end else if (pressed) begin
            state_d = StPaused;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        StPaused: begin
          if (cancel)       state_d = StConfig;
          else if (pressed) state_d = StRun;
        end
        StDone: begin
          if (cancel || pressed) state_d = StConfig;
        end
      endcase
    end

    if (!enable)                 disp_d = disp_q;
    else if (state_d == StConfig) disp_d = mode ? 16'h0000 : preset_d;
    else                         disp_d = count_d;
    finish_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StConfig;
      preset_q   <= PresetBcd;
      count_q    <= 16'h0000;
      run_mode_q <= 1'b0;
      select_q   <= 2'd0;
      div_q      <= '0;
      tick_q     <= 1'b0;
      finish_q   <= 1'b0;
      disp_q     <= mode ? 16'h0000 : PresetBcd;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      run_mode_q <= run_mode_d;
      select_q   <= select_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      finish_q   <= finish_d;
      disp_q     <= disp_d;
    end
  end

  assign {minute2, minute1, second2, second1} = disp_q;
  assign select = select_q;
  assign state  = state_q;
  assign finish = finish_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Scoreboard bench for mmss_timer: a seconds-based model pushes expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_mmss_timer;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned PresetSec = 5;
  localparam int unsigned UpLimit   = 65;

  localparam logic [5:0] BNone   = 6'b000000;
  localparam logic [5:0] BUp     = 6'b000001;
  localparam logic [5:0] BDown   = 6'b000010;
  localparam logic [5:0] BLeft   = 6'b000100;
  localparam logic [5:0] BRight  = 6'b001000;
  localparam logic [5:0] BPress  = 6'b010000;
  localparam logic [5:0] BCancel = 6'b100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic mode = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, pressed = 1'b0, cancel = 1'b0;
  logic [3:0] minute2, minute1, second2, second1;
  logic [1:0] select, state;
  logic       finish, tick;

  mmss_timer #(
    .TICK_DIV    (TickDiv),
    .PRESET_SEC  (PresetSec),
    .UP_LIMIT_SEC(UpLimit)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .pressed(pressed),
    .cancel (cancel),
    .minute2(minute2),
    .minute1(minute1),
    .second2(second2),
    .second1(second1),
    .select (select),
    .state  (state),
    .finish (finish),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [1:0]  st;
    logic [1:0]  sel;
    logic        fin;
    logic        tk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: times held as plain seconds; states 0 CONFIG, 1 RUN, 2 PAUSED, 3 DONE.
  int m_state = 0, m_sel = 0, m_preset = PresetSec, m_count = 0, m_div = 0, m_disp = PresetSec;
  bit m_up = 0, m_pend = 0, m_tick = 0;

  function automatic logic [15:0] to_digits(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic model_step();
    int w;
    m_tick = 0;
    if (rst) begin
      m_state = 0; m_sel = 0; m_preset = PresetSec; m_count = 0;
      m_div = 0; m_up = 0; m_pend = 0;
      m_disp = mode ? 0 : PresetSec;
    end else if (enable) begin
      case (m_state)
        0: begin
          w = (m_sel == 0) ? 1 : (m_sel == 1) ? 10 : (m_sel == 2) ? 60 : 600;
          if (pressed && (mode || m_preset != 0)) begin
            m_count = mode ? 0 : m_preset;
            m_up = mode; m_div = 0; m_state = 1;
          end
          if (left)       m_sel = (m_sel + 1) % 4;
          else if (right) m_sel = (m_sel + 3) % 4;
          if (!mode) begin
            if (up)        m_preset = (m_preset + w > 3599) ? 3599 : m_preset + w;
            else if (down) m_preset = (m_preset - w < 0) ? 0 : m_preset - w;
          end
        end
        1: begin
          if (cancel) begin
            m_state = 0; m_pend = 0;
          end else if (m_pend) begin
            m_state = 3; m_pend = 0;
          end else if (m_div == TickDiv - 1) begin
            m_div = 0; m_tick = 1;
            m_count = m_up ? m_count + 1 : m_count - 1;
            if (m_count == (m_up ? UpLimit : 0)) m_pend = 1;
            else if (pressed) m_state = 2;
          end else if (pressed) begin
            m_state = 2;
          end else begin
            m_div = m_div + 1;
          end
        end
        2: begin
          if (cancel)       m_state = 0;
          else if (pressed) m_state = 1;
        end
        default: begin
          if (cancel || pressed) m_state = 0;
        end
      endcase
      m_disp = (m_state == 0) ? (mode ? 0 : m_preset) : m_count;
    end
  endtask

  task automatic cyc(input logic [5:0] b);
    {cancel, pressed, right, left, down, up} = b;
    model_step();
    exp_q.push_back({to_digits(m_disp), 2'(m_state), 2'(m_sel), m_state == 3, m_tick});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(BNone);
  endtask

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("digits", {minute2, minute1, second2, second1}, e.digits);
      check("state", 16'(state), 16'(e.st));
      check("select", 16'(select), 16'(e.sel));
      check("finish", 16'(finish), 16'(e.fin));
      check("tick", 16'(tick), 16'(e.tk));
    end
  end

  initial begin
    logic [5:0] b;
    // Reset, countdown 00:05 to DONE, back to CONFIG.
    cyc(BNone); cyc(BNone);
    rst = 1'b0;
    cyc(BPress); idle(24); cyc(BPress); idle(2);
    // Preset editing and saturation.
    cyc(BLeft); repeat (6) cyc(BUp);
    cyc(BLeft); cyc(BLeft); repeat (6) cyc(BUp); repeat (6) cyc(BDown);
    cyc(BPress); idle(3);
    // Count-up to 01:05.
    mode = 1'b1; cyc(BPress); idle(265); cyc(BPress);
    mode = 1'b0; idle(2);
    rst = 1'b1; cyc(BNone); rst = 1'b0;
    // Pause/resume with divider held.
    cyc(BPress); idle(9); cyc(BPress); idle(20); cyc(BPress); idle(8);
    cyc(BCancel); idle(2);
    // Pressed coinciding with a tick.
    cyc(BPress); idle(3); cyc(BPress); idle(3); cyc(BCancel);
    // Enable low mid-run, then rst mid-run.
    cyc(BPress); idle(5); enable = 1'b0; idle(10); enable = 1'b1; idle(3);
    rst = 1'b1; cyc(BNone); rst = 1'b0; idle(2);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      b = BNone;
      if ($urandom_range(0, 9) == 0)  b = b | BUp;
      if ($urandom_range(0, 11) == 0) b = b | BDown;
      if ($urandom_range(0, 11) == 0) b = b | BLeft;
      if ($urandom_range(0, 11) == 0) b = b | BRight;
      if ($urandom_range(0, 7) == 0)  b = b | BPress;
      if ($urandom_range(0, 39) == 0) b = b | BCancel;
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      rst = ($urandom_range(0, 599) == 0);
      cyc(b);
    end
    rst = 1'b0; enable = 1'b1; idle(2);
    repeat (3) @(negedge clk);
    #1;
    check("drain", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
